// File: rtl/get_signal_multi.sv
// Samples NUM_CH serial ADCs sharing SCLK/CS once per SAMPLE_PERIOD and streams the
// 12-bit results as AXI4-Stream words, one frame of NUM_CH words written atomically into a FIFO.
module get_signal_multi #(
    parameter int NUM_CH                 = 2,
    parameter int CLK_TRIG               = 2,
    parameter int SAMPLE_PERIOD          = 128,
    parameter int RAM_ADDR_WIDTH         = 3,
    parameter int SIGNED_OUT             = 0,
    parameter int C_M00_AXIS_TDATA_WIDTH = 16,
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                                  m00_axis_aclk,
    input  logic                                  m00_axis_aresetn,
    input  logic                                  enable,
    output logic                                  m00_axis_tvalid,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic [CHW-1:0]                        m00_axis_tuser,
    output logic                                  m00_axis_tlast,
    input  logic                                  m00_axis_tready,
    output logic                                  spi_clock,
    output logic                                  spi_chipselect,
    input  logic [NUM_CH-1:0]                     spi_data,
    output logic                                  overflow,
    input  logic                                  clear_overflow
);

    localparam int TDW   = C_M00_AXIS_TDATA_WIDTH;
    localparam int AW    = RAM_ADDR_WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam int EW    = 1 + CHW + TDW;
    localparam int TW    = (CLK_TRIG > 1) ? $clog2(CLK_TRIG) : 1;
    localparam int PW    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

    localparam logic [TW-1:0]  TICK_LAST = TW'(CLK_TRIG - 1);
    localparam logic [PW-1:0]  CNT_LAST  = PW'(SAMPLE_PERIOD - 1);
    localparam logic [CHW-1:0] CH_LAST   = CHW'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_PUSH
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [TW-1:0]    r_tick, w_tick_nxt;
    logic [4:0]       r_half, w_half_nxt;
    logic             r_sclk, w_sclk_nxt;
    logic             r_cs, w_cs_nxt;
    logic [CHW-1:0]   r_pidx, w_pidx_nxt;
    logic             w_shift_en;
    logic             w_wr;
    logic             w_drop;

    logic [PW-1:0]    r_cnt;
    logic             w_start;
    logic             w_tick_done;

    logic [15:0]      r_shift [NUM_CH];
    logic [EW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_count;
    logic             w_pop;
    logic [AW+1:0]    w_free;
    logic [EW-1:0]    w_word;
    logic [EW-1:0]    w_rd;
    logic             r_overflow;

    // Discards the four leading zeros; signed mode flips offset-binary into two's complement.
    function automatic logic [TDW-1:0] fmt_sample(input logic [15:0] sh);
        logic [11:0]    s;
        logic [11:0]    t;
        logic [TDW-1:0] r;
        s = sh[11:0];
        t = {~s[11], s[10:0]};
        if (SIGNED_OUT != 0) r = {{(TDW-12){t[11]}}, t};
        else                 r = {{(TDW-12){1'b0}}, s};
        return r;
    endfunction

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn)                r_cnt <= '0;
        else if (!enable || r_cnt == CNT_LAST) r_cnt <= '0;
        else                                  r_cnt <= r_cnt + 1'b1;
    end

    assign w_start     = enable && (r_cnt == '0);
    assign w_tick_done = (r_tick == TICK_LAST);

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_half  <= '0;
            r_sclk  <= 1'b1;
            r_cs    <= 1'b1;
            r_pidx  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_half  <= w_half_nxt;
            r_sclk  <= w_sclk_nxt;
            r_cs    <= w_cs_nxt;
            r_pidx  <= w_pidx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_half_nxt  = r_half;
        w_sclk_nxt  = r_sclk;
        w_cs_nxt    = r_cs;
        w_pidx_nxt  = r_pidx;
        w_shift_en  = 1'b0;
        w_wr        = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_SETUP;
                    w_cs_nxt    = 1'b0;
                    w_tick_nxt  = '0;
                end
            end
            S_SETUP: begin
                if (w_tick_done) begin
                    w_state_nxt = S_SHIFT;
                    w_sclk_nxt  = 1'b0;
                    w_tick_nxt  = '0;
                    w_half_nxt  = '0;
                end else begin
                    w_tick_nxt = r_tick + 1'b1;
                end
            end
            S_SHIFT: begin
                // Even halves are SCLK low, odd halves high; data is captured on each rise.
                if (w_tick_done) begin
                    w_tick_nxt = '0;
                    if (r_half == 5'd31) begin
                        w_state_nxt = S_HOLD;
                        w_cs_nxt    = 1'b1;
                    end else begin
                        w_half_nxt = r_half + 1'b1;
                        w_sclk_nxt = ~r_sclk;
                        w_shift_en = ~r_sclk;
                    end
                end else begin
                    w_tick_nxt = r_tick + 1'b1;
                end
            end
            S_HOLD: begin
                if (w_tick_done) begin
                    w_state_nxt = S_PUSH;
                    w_tick_nxt  = '0;
                    w_pidx_nxt  = '0;
                end else begin
                    w_tick_nxt = r_tick + 1'b1;
                end
            end
            S_PUSH: begin
                if (r_pidx == '0 && w_free < (AW+2)'(NUM_CH)) begin
                    w_drop      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_wr = 1'b1;
                    if (r_pidx == CH_LAST) w_state_nxt = S_IDLE;
                    else                   w_pidx_nxt  = r_pidx + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge m00_axis_aclk) begin
        if (w_shift_en) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_shift[ch] <= {r_shift[ch][14:0], spi_data[ch]};
            end
        end
    end

    // Free space includes the slot released by a pop in the same cycle.
    assign w_pop  = (r_count != '0) && m00_axis_tready;
    assign w_free = (AW+2)'(DEPTH) - (AW+2)'(r_count) + (AW+2)'(w_pop);
    assign w_word = {(r_pidx == CH_LAST), r_pidx, fmt_sample(r_shift[r_pidx])};

    always_ff @(posedge m00_axis_aclk) begin
        if (w_wr) r_mem[r_wptr] <= w_word;
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn)   r_overflow <= 1'b0;
        else if (w_drop)         r_overflow <= 1'b1;
        else if (clear_overflow) r_overflow <= 1'b0;
    end

    assign w_rd            = r_mem[r_rptr];
    assign m00_axis_tvalid = (r_count != '0);
    assign m00_axis_tdata  = m00_axis_tvalid ? w_rd[TDW-1:0]   : '0;
    assign m00_axis_tuser  = m00_axis_tvalid ? w_rd[TDW +: CHW] : '0;
    assign m00_axis_tlast  = m00_axis_tvalid & w_rd[EW-1];
    assign m00_axis_tstrb  = '1;
    assign spi_clock       = r_sclk;
    assign spi_chipselect  = r_cs;
    assign overflow        = r_overflow;

endmodule

// File: tb/tb_get_signal_multi.sv
// Directed bench: an unsigned and a signed instance share stimulus and an ADC model
// that shifts out per-channel 16-bit patterns MSB-first on SCLK falling edges.
module tb_get_signal_multi;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        tready;
    logic        tready_req;
    logic        toggle_mode;
    logic        clear_ovf;
    logic [1:0]  spi_data;

    logic        tvalid_u, tlast_u, sclk, cs, ovf_u;
    logic [15:0] tdata_u;
    logic [1:0]  tstrb_u;
    logic [0:0]  tuser_u;
    logic        tvalid_s, tlast_s, sclk_s, cs_s, ovf_s;
    logic [15:0] tdata_s;
    logic [1:0]  tstrb_s;
    logic [0:0]  tuser_s;

    logic [15:0] pat [2];
    logic [17:0] qu [$];
    logic [17:0] qs [$];
    int          n_chk;
    int          n_pass;
    int          bu, bs;
    int          adc_idx;
    int          falls, low_cyc, last_falls, last_low, cs_fall_cnt;
    int          stall_seen, stall_viol;
    logic        stab_chk;

    typedef struct {
        logic [15:0] p0, p1;
        logic [15:0] u0, u1;
        logic [15:0] s0, s1;
    } vec_t;
    vec_t tv [4];

    get_signal_multi #(.SIGNED_OUT(0)) u_dut (
        .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .enable(enable),
        .m00_axis_tvalid(tvalid_u), .m00_axis_tdata(tdata_u), .m00_axis_tstrb(tstrb_u),
        .m00_axis_tuser(tuser_u), .m00_axis_tlast(tlast_u), .m00_axis_tready(tready),
        .spi_clock(sclk), .spi_chipselect(cs), .spi_data(spi_data),
        .overflow(ovf_u), .clear_overflow(clear_ovf)
    );

    get_signal_multi #(.SIGNED_OUT(1)) u_dut_s (
        .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .enable(enable),
        .m00_axis_tvalid(tvalid_s), .m00_axis_tdata(tdata_s), .m00_axis_tstrb(tstrb_s),
        .m00_axis_tuser(tuser_s), .m00_axis_tlast(tlast_s), .m00_axis_tready(tready),
        .spi_clock(sclk_s), .spi_chipselect(cs_s), .spi_data(spi_data),
        .overflow(ovf_s), .clear_overflow(clear_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tready = toggle_mode ? ~tready : tready_req;
        end
    end

    // Output capture, stall stability, frame statistics and the ADC responder.
    initial begin
        logic        prev_cs, prev_sclk, prev_stall;
        logic [17:0] prev_word;
        prev_cs = 1'b1; prev_sclk = 1'b1; prev_stall = 1'b0; prev_word = '0;
        spi_data = 2'b00; adc_idx = 15;
        falls = 0; low_cyc = 0; last_falls = 0; last_low = 0; cs_fall_cnt = 0;
        stall_seen = 0; stall_viol = 0;
        forever begin
            @(negedge clk);
            if (rst_n && tvalid_u && tready) qu.push_back({tlast_u, tuser_u, tdata_u});
            if (rst_n && tvalid_s && tready) qs.push_back({tlast_s, tuser_s, tdata_s});
            if (stab_chk && prev_stall) begin
                stall_seen++;
                if (!tvalid_u || {tlast_u, tuser_u, tdata_u} != prev_word) stall_viol++;
            end
            prev_stall = tvalid_u && !tready;
            prev_word  = {tlast_u, tuser_u, tdata_u};
            if (prev_cs && !cs) begin
                cs_fall_cnt++;
                falls = 0; low_cyc = 0; adc_idx = 15;
            end
            if (!cs) begin
                low_cyc++;
                if (prev_sclk && !sclk) begin
                    falls++;
                    if (adc_idx >= 0) begin
                        spi_data[0] = pat[0][adc_idx];
                        spi_data[1] = pat[1][adc_idx];
                    end
                    adc_idx--;
                end
            end
            if (!prev_cs && cs) begin
                last_falls = falls;
                last_low   = low_cyc;
            end
            prev_cs   = cs;
            prev_sclk = sclk;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic chk_word(input bit sgn, input int i, input logic [17:0] exp, input string nm);
        logic [17:0] w;
        if (sgn ? (i < qs.size()) : (i < qu.size())) begin
            w = sgn ? qs[i] : qu[i];
            chk(nm, 32'(w), 32'(exp));
        end else begin
            n_chk++;
            $display("FAIL %s: word %0d missing, expected 0x%0h", nm, i, exp);
        end
    endtask

    task automatic wait_cs(input logic level, input int budget, input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            if (cs === level) hit = 1'b1;
        end
        if (!hit) begin
            n_chk++;
            $display("FAIL %s: chipselect never reached %0b within %0d cycles", nm, level, budget);
        end
    endtask

    task automatic wait_words(input int n, input int budget, input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            if (qu.size() - bu >= n && qs.size() - bs >= n) hit = 1'b1;
        end
        if (!hit) begin
            n_chk++;
            $display("FAIL %s: got %0d words, expected %0d", nm, qu.size() - bu, n);
        end
    endtask

    initial begin
        n_chk = 0; n_pass = 0; bu = 0; bs = 0;
        tv[0] = '{16'h0ABC, 16'h0123, 16'h0ABC, 16'h0123, 16'h02BC, 16'hF923};
        tv[1] = '{16'h0000, 16'h0FFF, 16'h0000, 16'h0FFF, 16'hF800, 16'h07FF};
        tv[2] = '{16'h0800, 16'h07FF, 16'h0800, 16'h07FF, 16'h0000, 16'hFFFF};
        tv[3] = '{16'hF555, 16'h0AAA, 16'h0555, 16'h0AAA, 16'hFD55, 16'h02AA};

        rst_n = 1'b1; enable = 1'b0; tready_req = 1'b0; toggle_mode = 1'b0;
        clear_ovf = 1'b0; stab_chk = 1'b0;
        pat[0] = '0; pat[1] = '0;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", 32'(tvalid_u), 32'd0);
        chk("rst_tdata", 32'(tdata_u), 32'd0);
        chk("rst_tuser_tlast", 32'({tuser_u, tlast_u}), 32'd0);
        chk("rst_overflow", 32'({ovf_u, ovf_s}), 32'd0);
        chk("rst_spi_idle", 32'({sclk, cs, sclk_s, cs_s}), 32'hF);
        chk("tstrb", 32'({tstrb_u, tstrb_s}), 32'hF);
        rst_n = 1'b1;
        tready_req = 1'b1;
        repeat (3) @(negedge clk);

        // One frame per table row with a free-running consumer.
        for (int r = 0; r < 4; r++) begin
            pat[0] = tv[r].p0; pat[1] = tv[r].p1;
            bu = qu.size(); bs = qs.size();
            enable = 1'b1;
            wait_cs(1'b0, 20, "row_start");
            enable = 1'b0;
            wait_words(2, 200, "row_words");
            chk_word(1'b0, bu,     {2'b00, tv[r].u0}, $sformatf("row%0d_u_ch0", r));
            chk_word(1'b0, bu + 1, {2'b11, tv[r].u1}, $sformatf("row%0d_u_ch1", r));
            chk_word(1'b1, bs,     {2'b00, tv[r].s0}, $sformatf("row%0d_s_ch0", r));
            chk_word(1'b1, bs + 1, {2'b11, tv[r].s1}, $sformatf("row%0d_s_ch1", r));
            chk($sformatf("row%0d_sclk_falls", r), 32'(last_falls), 32'd16);
            chk($sformatf("row%0d_cs_low_cycles", r), 32'(last_low), 32'd66);
        end

        // Stalled consumer: five frames into an eight-word FIFO.
        tready_req = 1'b0;
        repeat (3) @(negedge clk);
        bu = qu.size(); bs = qs.size();
        enable = 1'b1;
        for (int f = 0; f < 5; f++) begin
            pat[0] = 16'h0A10 + 16'(f);
            pat[1] = 16'h0520 + 16'(f);
            wait_cs(1'b0, 300, "ovf_start");
            wait_cs(1'b1, 200, "ovf_end");
        end
        enable = 1'b0;
        repeat (20) @(negedge clk);
        chk("ovf_set", 32'({ovf_u, ovf_s}), 32'h3);
        chk("ovf_no_pop", 32'(qu.size() - bu), 32'd0);
        chk("ovf_head_held", 32'({tvalid_u, tlast_u, tuser_u, tdata_u}), 32'({3'b100, 16'h0A10}));
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        chk("ovf_cleared", 32'(ovf_u), 32'd0);
        tready_req = 1'b1;
        wait_words(8, 100, "ovf_drain");
        repeat (20) @(negedge clk);
        chk("ovf_word_count", 32'(qu.size() - bu), 32'd8);
        for (int i = 0; i < 8; i++) begin
            logic [15:0] d;
            d = (i % 2 == 0) ? 16'h0A10 + 16'(i / 2) : 16'h0520 + 16'(i / 2);
            chk_word(1'b0, bu + i, {(i % 2 == 1), (i % 2 == 1), d}, $sformatf("ovf_word%0d", i));
        end
        chk("ovf_empty", 32'(tvalid_u), 32'd0);

        // Consumer toggling ready every cycle.
        bu = qu.size(); bs = qs.size();
        toggle_mode = 1'b1; stab_chk = 1'b1;
        enable = 1'b1;
        for (int f = 0; f < 3; f++) begin
            pat[0] = 16'h0300 + 16'(f);
            pat[1] = 16'h0C00 + 16'(f);
            wait_cs(1'b0, 300, "tog_start");
            wait_cs(1'b1, 200, "tog_end");
        end
        enable = 1'b0;
        wait_words(6, 100, "tog_words");
        repeat (20) @(negedge clk);
        toggle_mode = 1'b0; stab_chk = 1'b0; tready_req = 1'b1;
        chk("tog_word_count", 32'(qu.size() - bu), 32'd6);
        for (int i = 0; i < 6; i++) begin
            logic [15:0] d;
            d = (i % 2 == 0) ? 16'h0300 + 16'(i / 2) : 16'h0C00 + 16'(i / 2);
            chk_word(1'b0, bu + i, {(i % 2 == 1), (i % 2 == 1), d}, $sformatf("tog_word%0d", i));
        end
        chk("tog_stall_stable", 32'(stall_viol), 32'd0);
        chk("tog_stall_seen", 32'(stall_seen > 0), 32'd1);
        repeat (3) @(negedge clk);

        // Reset in the middle of the shift phase.
        pat[0] = 16'h0456; pat[1] = 16'h0789;
        enable = 1'b1;
        wait_cs(1'b0, 20, "rst_mid_start");
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_spi_idle", 32'({sclk, cs}), 32'h3);
        chk("rst_mid_tvalid", 32'(tvalid_u), 32'd0);
        repeat (3) @(negedge clk);
        bu = qu.size(); bs = qs.size();
        rst_n = 1'b1;
        wait_cs(1'b0, 20, "rst_after_start");
        enable = 1'b0;
        wait_words(2, 200, "rst_after_words");
        repeat (10) @(negedge clk);
        chk("rst_after_count", 32'(qu.size() - bu), 32'd2);
        chk_word(1'b0, bu,     {2'b00, 16'h0456}, "rst_after_ch0");
        chk_word(1'b0, bu + 1, {2'b11, 16'h0789}, "rst_after_ch1");

        // Enable dropped during shift, then re-enabled.
        pat[0] = 16'h0DEF; pat[1] = 16'h0111;
        bu = qu.size(); bs = qs.size();
        enable = 1'b1;
        wait_cs(1'b0, 20, "en_start");
        repeat (10) @(negedge clk);
        enable = 1'b0;
        wait_words(2, 200, "en_words");
        chk_word(1'b0, bu,     {2'b00, 16'h0DEF}, "en_ch0");
        chk_word(1'b0, bu + 1, {2'b11, 16'h0111}, "en_ch1");
        begin
            int falls_before;
            falls_before = cs_fall_cnt;
            repeat (300) @(negedge clk);
            chk("en_no_cs_activity", 32'(cs_fall_cnt - falls_before), 32'd0);
        end
        @(posedge clk);
        #1 enable = 1'b1;
        @(negedge clk);
        chk("reen_cs_before", 32'(cs), 32'd1);
        @(negedge clk);
        chk("reen_cs_next", 32'(cs), 32'd0);
        enable = 1'b0;
        bu = qu.size(); bs = qs.size();
        wait_words(2, 200, "reen_words");
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
